ahb_sram_subordinate: RTL and testbench
=======================================

# ahb_sram_subordinate

AHB-Lite subordinate with word-organised local memory, at the response end of the shared bus behind the multi-manager arbiter. Accepts the granted manager's address phase, completes reads and byte-lane writes after a fixed number of wait states, and returns a two-cycle ERROR response for illegal accesses. Provides a known-latency target for arbitration and multi-manager integration tests.

## Interface
- ADDR_WIDTH, 32, HADDR width
- DATA_WIDTH, 32, HWDATA/HRDATA width; 32 only in this revision
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of two
- WAIT_STATES, 1, HREADYOUT-low cycles per OKAY transfer; 0..7

- HCLK  in  1  bus clock; all state updates on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  subordinate select from address decoder
- HADDR  in  ADDR_WIDTH  byte address
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
- HWRITE  in  1  1 = write
- HSIZE  in  3  0=byte, 1=half, 2=word; larger is illegal
- HBURST  in  3  accepted and ignored; each beat is an independent transfer
- HWDATA  in  DATA_WIDTH  write data, sampled in data phase
- HREADY  in  1  bus-level ready, gating address-phase acceptance
- HRDATA  out  DATA_WIDTH  read data
- HREADYOUT  out  1  this subordinate's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Latch HADDR, HWRITE, HSIZE, legality flag.
- HSEL & HREADY with IDLE/BUSY, or HSEL=0: no transfer; next cycle zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Illegal: HSIZE>2; misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0); word index HADDR[ADDR_WIDTH-1:2] >= MEM_DEPTH.
- States: IDLE, WAIT, LAST, ERR1, ERR2.
  - IDLE: legal accept -> WAIT if WAIT_STATES>0, else LAST; illegal accept -> ERR1.
  - WAIT: count down from WAIT_STATES; HREADYOUT=0; at count 1 -> LAST.
  - LAST: HREADYOUT=1, HRESP=0; commit write or drive read data; new accept goes to WAIT/LAST/ERR1 as from IDLE (back-to-back pipelining), else IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; accepts a new address phase like LAST.
- Writes: byte enables from latched HSIZE and HADDR[1:0]; lanes little-endian (byte at address offset n on HWDATA[8n+7:8n]). Write commits on the LAST-cycle clock edge only; unselected lanes unchanged.
- Reads: HRDATA = full addressed word during LAST; lane selection is the manager's job. HRDATA = 0 in all other cycles.
- Illegal transfers never modify memory.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0. Memory array not reset.
- OKAY latency: WAIT_STATES+1 data-phase cycles after the address-phase edge.
- ERROR: exactly 2 data-phase cycles regardless of WAIT_STATES.
- Read issued in the LAST cycle of a write to the same word returns the newly written data (write commits before the read's data phase).
- HRESET mid-transfer: abort immediately to reset values; an uncommitted write is dropped.
- HTRANS, HSEL and HADDR ignored while HREADY=0.

## Structure
- Package ahb_pkg: htrans_t enum, hsize_t, HRESP_OKAY/HRESP_ERROR constants, subordinate state enum (shared with future subordinates and manager agents).
- Sub-module ahb_lane_decode: HSIZE + HADDR[1:0] -> 4-bit byte enable and misalign flag, combinational.
- Memory: flop array inside the top module; no SRAM macro.

## Test plan
- Reset: assert HRESET during a WAIT cycle -> HREADYOUT=1, HRESP=0, HRDATA=0 next cycle; the pending write is absent on readback.
- WAIT_STATES=1: word write 0xDEADBEEF to 0x10, then read 0x10 -> each transfer 1 low + 1 high HREADYOUT cycle; HRDATA=0xDEADBEEF.
- Byte lanes: word 0x11223344 at 0x20, byte write 0xAA to 0x21, half write 0xBBCC to 0x22 -> read 0x20 gives 0xBBCCAA44.
- Errors: word read at 0x02, HSIZE=3 at 0x00, address MEM_DEPTH*4 -> each gives HREADYOUT 0 then 1 with HRESP=1 both cycles; memory unchanged.
- Pipelining, WAIT_STATES=0: NONSEQ write 0x5 to 0x30 followed immediately by SEQ read 0x30 -> HREADYOUT stays 1, read returns 0x5.
- IDLE/BUSY with HSEL=1 and HREADY=0 stalls -> zero-wait OKAY, no accept, no memory change.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for subordinates and manager agents.
// Holds transfer-type and size encodings, response constants and the
// subordinate data-phase state encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        SUB_IDLE = 3'd0,
        SUB_WAIT = 3'd1,
        SUB_LAST = 3'd2,
        SUB_ERR1 = 3'd3,
        SUB_ERR2 = 3'd4
    } sub_state_t;

endpackage

// File: rtl/ahb_lane_decode.sv
// Byte-lane decode: transfer size + low address bits -> 4-bit byte enable.
// Purely combinational, no latency.
// No flow control; sizes above word give no lanes and no misalign flag.
module ahb_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] byte_en,
    output logic       misalign
);

    // Little-endian lanes: byte at offset n lives on byte lane n.
    always_comb begin
        byte_en  = 4'b0000;
        misalign = 1'b0;
        if (hsize == HSIZE_BYTE) begin
            byte_en = 4'b0001 << addr_lo;
        end else if (hsize == HSIZE_HALF) begin
            byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
        end else if (hsize == HSIZE_WORD) begin
            byte_en  = 4'b1111;
            misalign = (addr_lo != 2'b00);
        end
    end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised flop memory.
// OKAY transfers take WAIT_STATES+1 data-phase cycles; ERROR takes exactly 2.
// Stalls the bus with HREADYOUT low during wait and first error cycles.
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int WIDX_W = ADDR_WIDTH - 2;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    sub_state_t       state, state_nxt;
    logic [2:0]       wait_cnt, wait_nxt;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic [3:0]       be_q;

    logic [3:0] be_d;
    logic       misalign;
    logic       accept;
    logic       can_accept;
    logic       size_bad;
    logic       range_bad;
    logic       legal;

    // Burst type and the BUSY/IDLE distinction carry no meaning here:
    // every beat is handled as an independent transfer.
    logic unused_bits;
    assign unused_bits = ^{HTRANS[0], HBURST};

    ahb_lane_decode u_lane_decode (
        .hsize    (HSIZE),
        .addr_lo  (HADDR[1:0]),
        .byte_en  (be_d),
        .misalign (misalign)
    );

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign can_accept = (state == SUB_IDLE) || (state == SUB_LAST) || (state == SUB_ERR2);
    assign size_bad   = (HSIZE > 3'd2);
    assign range_bad  = (HADDR[ADDR_WIDTH-1:2] >= WIDX_W'(MEM_DEPTH));
    assign legal      = !size_bad && !misalign && !range_bad;

    // Data-phase sequencing; ready states take a new address phase directly.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            SUB_WAIT: begin
                if (wait_cnt <= 3'd1) begin
                    state_nxt = SUB_LAST;
                    wait_nxt  = 3'd0;
                end else begin
                    wait_nxt = wait_cnt - 3'd1;
                end
            end
            SUB_ERR1: state_nxt = SUB_ERR2;
            default: begin
                state_nxt = SUB_IDLE;
                wait_nxt  = 3'd0;
                if (accept) begin
                    if (!legal) begin
                        state_nxt = SUB_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = SUB_WAIT;
                        wait_nxt  = 3'(WAIT_STATES);
                    end else begin
                        state_nxt = SUB_LAST;
                    end
                end
            end
        endcase
    end

    // State, counter and latched address-phase controls.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= SUB_IDLE;
            wait_cnt <= 3'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            be_q     <= 4'b0000;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (accept && can_accept) begin
                idx_q   <= HADDR[IDX_W+1:2];
                write_q <= HWRITE && legal;
                be_q    <= be_d;
            end
        end
    end

    // Write commit on the LAST edge only; unselected lanes keep their bytes.
    always_ff @(posedge HCLK) begin
        if (state == SUB_LAST && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Response outputs decoded from the current state.
    always_comb begin
        HREADYOUT = !((state == SUB_WAIT) || (state == SUB_ERR1));
        HRESP     = ((state == SUB_ERR1) || (state == SUB_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA    = '0;
        if (state == SUB_LAST && !write_q) begin
            HRDATA = mem[idx_q];
        end
    end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed bench: two subordinates (1 and 0 wait states) behind a tiny
// decoder mux, driven one transfer at a time with hand-computed results.
module tb_ahb_sram_subordinate;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        stall;
    logic        sel0;

    logic [31:0] rd1, rd0;
    logic        ro1, ro0, rp1, rp0;
    logic        hready_bus;
    logic        hresp_bus;
    logic [31:0] rdata_bus;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign hready_bus = ~stall & (sel0 ? ro0 : ro1);
    assign hresp_bus  = sel0 ? rp0 : rp1;
    assign rdata_bus  = sel0 ? rd0 : rd1;

    ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(1)) dut1 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel & ~sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HWDATA(hwdata), .HREADY(hready_bus),
        .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rp1)
    );

    ahb_sram_subordinate #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel & sel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd1), .HWDATA(hwdata), .HREADY(hready_bus),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rp0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
        haddr  = 32'd0;
        hsize  = 3'd0;
    endtask

    // Entered just after a rising edge with the bus ready.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        input int exp_low, input logic exp_resp, input logic [31:0] exp_rdata);
        int   lows;
        logic done;
        hsel   = 1'b1;
        htrans = 2'd2;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        @(posedge clk); #1;
        bus_idle();
        hwdata = wdata;
        lows = 0;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (hready_bus) begin
                done = 1'b1;
            end else begin
                lows++;
                if (exp_resp) check({tag, "_resp_lo"}, 32'(hresp_bus), 32'd1);
                else if (!wr) check({tag, "_rdata_wait"}, rdata_bus, 32'd0);
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lows"}, 32'(lows), 32'(exp_low));
        check({tag, "_resp"}, 32'(hresp_bus), 32'(exp_resp));
        if (!wr) check({tag, "_rdata"}, rdata_bus, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        sel0   = 1'b0;
        hwdata = 32'd0;
        bus_idle();

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ro1", 32'(ro1), 32'd1);
        check("rst_rp1", 32'(rp1), 32'd0);
        check("rst_rd1", rd1, 32'd0);
        check("rst_ro0", 32'(ro0), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Word write/read, one wait state
        xfer("wr10", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 1, 1'b0, 32'd0);
        xfer("rd10", 1'b0, 32'h10, 3'd2, 32'd0, 1, 1'b0, 32'hDEADBEEF);

        // Byte lanes
        xfer("wr20",  1'b1, 32'h20, 3'd2, 32'h11223344, 1, 1'b0, 32'd0);
        xfer("wrb21", 1'b1, 32'h21, 3'd0, 32'h0000AA00, 1, 1'b0, 32'd0);
        xfer("wrh22", 1'b1, 32'h22, 3'd1, 32'hBBCC0000, 1, 1'b0, 32'd0);
        xfer("rd20",  1'b0, 32'h20, 3'd2, 32'd0, 1, 1'b0, 32'hBBCCAA44);

        // Errors leave memory untouched
        xfer("wr00",    1'b1, 32'h00,  3'd2, 32'h01020304, 1, 1'b0, 32'd0);
        xfer("e_mis",   1'b0, 32'h02,  3'd2, 32'd0,        1, 1'b1, 32'd0);
        xfer("e_mis_w", 1'b1, 32'h02,  3'd2, 32'hFFFFFFFF, 1, 1'b1, 32'd0);
        xfer("e_size",  1'b1, 32'h00,  3'd3, 32'hFFFFFFFF, 1, 1'b1, 32'd0);
        xfer("e_range", 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF, 1, 1'b1, 32'd0);
        xfer("e_half",  1'b1, 32'h01,  3'd1, 32'hFFFFFFFF, 1, 1'b1, 32'd0);
        xfer("rd00",    1'b0, 32'h00,  3'd2, 32'd0, 1, 1'b0, 32'h01020304);
        xfer("rd3fc",   1'b1, 32'h3FC, 3'd2, 32'h0000_3FC0, 1, 1'b0, 32'd0);
        xfer("rd3fc_r", 1'b0, 32'h3FC, 3'd2, 32'd0, 1, 1'b0, 32'h0000_3FC0);

        // Reset mid-transfer drops the pending write
        xfer("pre40", 1'b1, 32'h40, 3'd2, 32'h12345678, 1, 1'b0, 32'd0);
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_wait_lo", 32'(hready_bus), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_mid_ro", 32'(ro1), 32'd1);
        check("rst_mid_rp", 32'(rp1), 32'd0);
        check("rst_mid_rd", rd1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xfer("rd40", 1'b0, 32'h40, 3'd2, 32'd0, 1, 1'b0, 32'h12345678);

        // Stalled NONSEQ then IDLE/BUSY: never accepted
        stall = 1'b1;
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; hwdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        stall  = 1'b0;
        htrans = 2'd0;
        @(posedge clk); #1;
        htrans = 2'd1;
        @(negedge clk);
        check("stall_idle_ro", 32'(ro1), 32'd1);
        check("stall_idle_rp", 32'(rp1), 32'd0);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("stall_busy_ro", 32'(ro1), 32'd1);
        @(posedge clk); #1;
        xfer("rd10_stall", 1'b0, 32'h10, 3'd2, 32'd0, 1, 1'b0, 32'hDEADBEEF);

        // Zero wait states: back-to-back write then read of the same word
        sel0 = 1'b1;
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        @(posedge clk); #1;
        hwdata = 32'h5;
        htrans = 2'd3;
        hwrite = 1'b0;
        @(negedge clk);
        check("pl_wr_rdy", 32'(hready_bus), 32'd1);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("pl_rd_rdy",  32'(hready_bus), 32'd1);
        check("pl_rd_resp", 32'(hresp_bus), 32'd0);
        check("pl_rd_data", rdata_bus, 32'h5);
        @(posedge clk); #1;
        xfer("z_err", 1'b0, 32'h01, 3'd2, 32'd0, 1, 1'b1, 32'd0);
        xfer("z_rd30", 1'b0, 32'h30, 3'd2, 32'd0, 0, 1'b0, 32'h5);
        sel0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
